aes128_inv_key_expansion: RTL and testbench

Byte-serial AES-128 inverse key schedule for the decryption datapath. It loads the round-10 key and steps backwards one round per request, ending at the original cipher key. It therefore supplies round keys in the order the inverse cipher consumes them. It shares the single-S-box, byte-at-a-time structure of the forward key schedule and can borrow the external S-box port.

---
 rtl/aes128_inv_key_expansion.sv | 161 ++++++++++++++++
 tb/tb_aes128_inv_key_expansion.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_inv_key_expansion.sv
// Byte-serial AES-128 inverse key schedule: steps from the round-10 key back to the
// cipher key, one round per request, using a single (internal or external) S-box.
module aes128_inv_key_expansion #(
  parameter bit EXTERNAL_SBOX = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [127:0] key_i,
  input  logic         start_i,
  input  logic         key_req_i,
  output logic [127:0] key_o,
  output logic [127:0] key_big_end_o,
  output logic [3:0]   round_o,
  output logic         valid_o,
  output logic [7:0]   sbox_sub_o,
  input  logic [7:0]   sbox_sub_i
);

  typedef enum logic [2:0] {
    ST_WAIT, ST_XOR, ST_ROT, ST_SUB, ST_RCON, ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0][31:0]  w_reg, w_next;
  logic [31:0]       manip_reg, manip_next;
  logic [7:0]        rcon_reg, rcon_next;
  logic [3:0]        round_reg, round_next;
  logic              valid_reg, valid_next;
  logic [1:0]        xor_cnt_reg, xor_cnt_next;
  logic [1:0]        addr_reg, addr_next;
  logic [1:0]        xor_lo;
  logic [127:0]      key_rev;
  logic [7:0]        sub_result;
  logic              unused_sbox_in;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128), then the AES affine map.
  function automatic logic [7:0] sbox_fn(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      assign key_rev[8*gi +: 8]          = key_i[127-8*gi -: 8];
      assign key_big_end_o[127-8*gi -: 8] = key_o[8*gi +: 8];
    end
    if (EXTERNAL_SBOX) begin : g_ext_sbox
      assign sub_result = sbox_sub_i;
    end else begin : g_int_sbox
      assign sub_result = sbox_fn(sbox_sub_o);
    end
  endgenerate

  assign unused_sbox_in = ^sbox_sub_i;
  assign key_o      = w_reg;
  assign round_o    = round_reg;
  assign valid_o    = valid_reg;
  assign xor_lo     = xor_cnt_reg - 2'd1;
  assign sbox_sub_o = (state_reg == ST_SUB) ? manip_reg[{addr_reg, 3'b000} +: 8] : 8'h00;

  always_comb begin
    state_next   = state_reg;
    w_next       = w_reg;
    manip_next   = manip_reg;
    rcon_next    = rcon_reg;
    round_next   = round_reg;
    valid_next   = valid_reg;
    xor_cnt_next = xor_cnt_reg;
    addr_next    = addr_reg;
    // start_i aborts any step in progress and reloads from scratch
    if (start_i) begin
      w_next     = key_rev;
      round_next = 4'd10;
      rcon_next  = 8'h36;
      valid_next = 1'b1;
      state_next = ST_WAIT;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          if (key_req_i && valid_reg && (round_reg != 4'd0)) begin
            valid_next   = 1'b0;
            xor_cnt_next = 2'd3;
            state_next   = ST_XOR;
          end
        end
        ST_XOR: begin
          // Descending order: the lower word is still the unmodified one.
          w_next[xor_cnt_reg] = w_reg[xor_cnt_reg] ^ w_reg[xor_lo];
          xor_cnt_next        = xor_lo;
          if (xor_cnt_reg == 2'd1) state_next = ST_ROT;
        end
        ST_ROT: begin
          manip_next = {w_reg[3][7:0], w_reg[3][31:8]};
          addr_next  = 2'd0;
          state_next = ST_SUB;
        end
        ST_SUB: begin
          manip_next[{addr_reg, 3'b000} +: 8] = sub_result;
          addr_next = addr_reg + 2'd1;
          if (addr_reg == 2'd3) state_next = ST_RCON;
        end
        ST_RCON: begin
          manip_next = manip_reg ^ {24'h000000, rcon_reg};
          state_next = ST_DONE;
        end
        ST_DONE: begin
          w_next[0]  = w_reg[0] ^ manip_reg;
          round_next = round_reg - 4'd1;
          rcon_next  = rcon_reg[0] ? ((rcon_reg >> 1) ^ 8'h8d) : (rcon_reg >> 1);
          valid_next = 1'b1;
          state_next = ST_WAIT;
        end
        default: state_next = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg   <= ST_WAIT;
      w_reg       <= '0;
      manip_reg   <= '0;
      rcon_reg    <= '0;
      round_reg   <= '0;
      valid_reg   <= 1'b0;
      xor_cnt_reg <= '0;
      addr_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      w_reg       <= w_next;
      manip_reg   <= manip_next;
      rcon_reg    <= rcon_next;
      round_reg   <= round_next;
      valid_reg   <= valid_next;
      xor_cnt_reg <= xor_cnt_next;
      addr_reg    <= addr_next;
    end
  end

endmodule

// File: tb/tb_aes128_inv_key_expansion.sv
// Bench for the inverse key schedule: internal and external S-box instances side by side,
// checked against a word-level AES key-schedule model.
module tb_aes128_inv_key_expansion;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic [127:0] key_i;
  logic         start_i;
  logic         key_req_i;

  logic [127:0] int_key, int_key_be, ext_key, ext_key_be;
  logic [3:0]   int_round, ext_round;
  logic         int_valid, ext_valid;
  logic [7:0]   int_sub_o, ext_sub_o, ext_sub_i;

  logic [7:0]   sbox_tab [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  assign ext_sub_i = sbox_tab[ext_sub_o];

  aes128_inv_key_expansion #(.EXTERNAL_SBOX(1'b0)) dut_int (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .key_i(key_i), .start_i(start_i),
    .key_req_i(key_req_i), .key_o(int_key), .key_big_end_o(int_key_be),
    .round_o(int_round), .valid_o(int_valid), .sbox_sub_o(int_sub_o), .sbox_sub_i(8'h00));

  aes128_inv_key_expansion #(.EXTERNAL_SBOX(1'b1)) dut_ext (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .key_i(key_i), .start_i(start_i),
    .key_req_i(key_req_i), .key_o(ext_key), .key_big_end_o(ext_key_be),
    .round_o(ext_round), .valid_o(ext_valid), .sbox_sub_o(ext_sub_o), .sbox_sub_i(ext_sub_i));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] byte_rev(input logic [127:0] k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = k[127-8*i -: 8];
    return r;
  endfunction

  // Previous round key in FIPS-197 word form; r is the round being left.
  function automatic logic [127:0] model_prev(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3, t, s;
    {w0, w1, w2, w3} = k;
    n3 = w3 ^ w2;
    n2 = w2 ^ w1;
    n1 = w1 ^ w0;
    t  = {n3[23:0], n3[31:24]};
    for (int j = 0; j < 4; j++) s[8*j +: 8] = sbox_tab[t[8*j +: 8]];
    n0 = w0 ^ s ^ {rcon_tab[r-1], 24'h000000};
    return {n0, n1, n2, n3};
  endfunction

  task automatic check_state(input string tag, input logic [127:0] be,
                             input logic [3:0] rnd, input logic vld);
    chk({tag, " int key_be"}, int_key_be, be);
    chk({tag, " int key_o"}, int_key, byte_rev(be));
    chk({tag, " int round"}, {124'd0, int_round}, {124'd0, rnd});
    chk({tag, " int valid"}, {127'd0, int_valid}, {127'd0, vld});
    chk({tag, " ext key_be"}, ext_key_be, be);
    chk({tag, " ext round"}, {124'd0, ext_round}, {124'd0, rnd});
    chk({tag, " ext valid"}, {127'd0, ext_valid}, {127'd0, vld});
  endtask

  task automatic load(input logic [127:0] k, input string tag);
    key_i   = k;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_state({tag, " load"}, k, 4'd10, 1'b1);
  endtask

  // Caller has set key_req_i; measures busy length and S-box port activity.
  task automatic do_step(input logic [127:0] be, input logic [3:0] rnd,
                         input logic hold, input string tag);
    int n;
    int bad;
    tick();
    if (!hold) key_req_i = 1'b0;
    n   = 0;
    bad = 0;
    while (!int_valid && n < 40) begin
      if ((int_sub_o != 8'h00 || ext_sub_o != 8'h00) && !(n >= 4 && n <= 7)) bad++;
      tick();
      n++;
    end
    chk({tag, " busy cycles"}, 128'(n), 128'd10);
    chk({tag, " sbox outside SUB"}, 128'(bad), 128'd0);
    check_state(tag, be, rnd, 1'b1);
    $display("step %s: round=%0d key=%h", tag, int_round, int_key_be);
  endtask

  initial begin
    logic [127:0] cur, nxt, k2;
    logic [7:0] p, q;
    int n;
    // S-box table from the GF(2^8) generator walk (p by 3, q by 1/3).
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sbox_tab[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^
                    {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;

    rst_n_i = 1'b0; start_i = 1'b0; key_req_i = 1'b0; key_i = '0;
    tick(); tick();
    rst_n_i = 1'b1;
    check_state("reset", 128'd0, 4'd0, 1'b0);
    chk("reset sbox_sub_o", {120'd0, int_sub_o}, 128'd0);

    // Request before any key is loaded is ignored.
    key_req_i = 1'b1;
    tick();
    key_req_i = 1'b0;
    tick();
    check_state("req unloaded", 128'd0, 4'd0, 1'b0);

    // FIPS-197 walk from round 10 to round 0.
    cur = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    load(cur, "fips");
    for (int r = 10; r >= 1; r--) begin
      nxt = model_prev(cur, r);
      key_req_i = 1'b1;
      do_step(nxt, 4'(r - 1), 1'b0, $sformatf("fips r%0d", r - 1));
      if (r == 10) chk("fips round9", int_key_be, 128'hac7766f319fadc2128d12941575c006e);
      if (r == 2)  chk("fips round1", int_key_be, 128'ha0fafe1788542cb123a339392a6c7605);
      cur = nxt;
    end
    chk("fips round0", int_key_be, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips round0 ext", ext_key_be, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // 11th request at round 0 is ignored.
    key_req_i = 1'b1;
    tick();
    key_req_i = 1'b0;
    tick(); tick();
    check_state("req at round0", 128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0, 1'b1);

    // Random keys with key_req_i held high: back-to-back steps.
    for (int t = 0; t < 3; t++) begin
      cur = {$urandom, $urandom, $urandom, $urandom};
      load(cur, $sformatf("rnd%0d", t));
      key_req_i = 1'b1;
      for (int r = 10; r >= 1; r--) begin
        nxt = model_prev(cur, r);
        do_step(nxt, 4'(r - 1), 1'b1, $sformatf("rnd%0d r%0d", t, r - 1));
        cur = nxt;
      end
      tick(); tick(); tick();
      key_req_i = 1'b0;
      check_state($sformatf("rnd%0d held at 0", t), cur, 4'd0, 1'b1);
    end

    // Start with key_req_i together in WAIT: start wins.
    cur = {$urandom, $urandom, $urandom, $urandom};
    key_req_i = 1'b1;
    load(cur, "start+req");
    key_req_i = 1'b0;

    // Abort during SUB with a new key; rcon must restart at 36.
    key_req_i = 1'b1;
    tick();
    key_req_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("in SUB before abort", {127'd0, int_valid}, 128'd0);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    load(k2, "abort");
    key_req_i = 1'b1;
    do_step(model_prev(k2, 10), 4'd9, 1'b0, "after abort");

    // Asynchronous reset mid-XOR, between clock edges.
    load(cur, "pre-reset");
    key_req_i = 1'b1;
    tick();
    key_req_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    check_state("async reset", 128'd0, 4'd0, 1'b0);
    chk("async reset sbox", {120'd0, int_sub_o}, 128'd0);
    tick();
    rst_n_i = 1'b1;
    key_req_i = 1'b1;
    tick();
    key_req_i = 1'b0;
    n = 0;
    while (n < 12) begin
      tick();
      n++;
    end
    check_state("req after reset", 128'd0, 4'd0, 1'b0);
    load(cur, "reload");
    key_req_i = 1'b1;
    do_step(model_prev(cur, 10), 4'd9, 1'b0, "reload step");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
